// File: rtl/waveform_readback_pkg.sv
// Shared AXI encodings and the acquisition state encoding (common with the
// recorder so status readback decodes the same way in both blocks).
package waveform_readback_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_FINISH = 3'd4,
    ST_FLUSH  = 3'd5
  } state_t;

endpackage

// File: rtl/waveform_readback_fifo.sv
// FWFT FIFO with free-word count and single-cycle flush; a pushed word is
// visible on the next cycle, and rd only pops while valid is high.
module waveform_readback_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] free
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr, count;
  logic             full;

  assign count = wr_ptr - rd_ptr;
  assign valid = count != '0;
  assign full  = count == DEPTH_L;
  assign free  = DEPTH_L - count;
  assign rdata = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (wr && !full) mem[wr_ptr[PW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (wr && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd && valid) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/waveform_readback.sv
// AXI4 read master streaming a wrapped waveform window out of the acquisition
// buffer; R beat to m_valid is 1 cycle, and bursts are only issued with a full burst of FIFO space.
module waveform_readback
  import waveform_readback_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int ACQ_CAPACITY   = 1 << 23,
  parameter int BURST_LEN      = 8,
  parameter int FIFO_CAPACITY  = 32
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              start,
  input  logic                              abort,
  input  logic [AXI_ADDR_WIDTH-1:0]         base,
  input  logic [$clog2(ACQ_CAPACITY)-1:0]   startWord,
  input  logic [$clog2(ACQ_CAPACITY+1)-1:0] wordCount,
  output logic                              busy,
  output logic                              done,
  output logic                              rrespErr,
  output logic [1:0]                        rresp,
  output logic [AXI_ADDR_WIDTH-1:0]         axi_ARADDR,
  output logic [7:0]                        axi_ARLEN,
  output logic [2:0]                        axi_ARSIZE,
  output logic [1:0]                        axi_ARBURST,
  output logic                              axi_ARVALID,
  input  logic                              axi_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]         axi_RDATA,
  input  logic [1:0]                        axi_RRESP,
  input  logic                              axi_RLAST,
  input  logic                              axi_RVALID,
  output logic                              axi_RREADY,
  output logic [AXI_DATA_WIDTH-1:0]         m_data,
  output logic                              m_valid,
  output logic                              m_last,
  input  logic                              m_ready
);

  localparam int RA_W    = $clog2(ACQ_CAPACITY);
  localparam int CNT_W   = $clog2(ACQ_CAPACITY+1);
  localparam int LEN_W   = $clog2(BURST_LEN+1);
  localparam int BYTE_SH = $clog2(AXI_DATA_WIDTH/8);
  localparam int FREE_W  = $clog2(FIFO_CAPACITY+1);
  localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK =
    (AXI_ADDR_WIDTH'(1) << (RA_W + BYTE_SH)) - AXI_ADDR_WIDTH'(1);

  state_t                    state;
  logic [RA_W-1:0]           read_addr;
  logic [CNT_W-1:0]          left;
  logic [LEN_W-1:0]          cur_len, room, next_len;
  logic [AXI_ADDR_WIDTH-1:0] base_q, next_araddr;
  logic                      abort_pend, push, beat_err, beat_last, flush, fifo_valid;
  logic [FREE_W-1:0]         free;
  logic [AXI_DATA_WIDTH:0]   fifo_out;

  assign axi_ARSIZE  = 3'(BYTE_SH);
  assign axi_ARBURST = BURST_INCR;
  assign axi_RREADY  = state != ST_IDLE;
  assign m_valid     = fifo_valid;
  assign m_data      = fifo_out[AXI_DATA_WIDTH-1:0];
  assign m_last      = fifo_valid && fifo_out[AXI_DATA_WIDTH];

  // Bursts stop at the next BURST_LEN boundary, so none crosses a 4 KB page or the buffer end.
  always_comb begin
    room        = LEN_W'(BURST_LEN - 32'(read_addr) % BURST_LEN);
    next_len    = (left < CNT_W'(room)) ? left[LEN_W-1:0] : room;
    next_araddr = (base_q & ~LOW_MASK) | (AXI_ADDR_WIDTH'(read_addr) << BYTE_SH);
    beat_err    = axi_RRESP != RESP_OKAY;
    push        = (state == ST_DATA) && axi_RVALID && !abort_pend && !abort;
    beat_last   = axi_RLAST && (left == '0) && !rrespErr && !beat_err;
    flush       = state == ST_FLUSH;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      read_addr   <= '0;
      left        <= '0;
      cur_len     <= '0;
      base_q      <= '0;
      abort_pend  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rrespErr    <= 1'b0;
      rresp       <= RESP_OKAY;
      axi_ARVALID <= 1'b0;
      axi_ARADDR  <= '0;
      axi_ARLEN   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            read_addr  <= startWord;
            left       <= wordCount;
            base_q     <= base;
            rrespErr   <= 1'b0;
            rresp      <= RESP_OKAY;
            abort_pend <= 1'b0;
            if (wordCount == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (abort) begin
            state <= ST_FLUSH;
          end else if (free >= FREE_W'(BURST_LEN)) begin
            cur_len     <= next_len;
            axi_ARLEN   <= 8'(next_len - 1'b1);
            axi_ARADDR  <= next_araddr;
            axi_ARVALID <= 1'b1;
            state       <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (abort) abort_pend <= 1'b1;
          if (axi_ARREADY) begin
            axi_ARVALID <= 1'b0;
            read_addr   <= read_addr + RA_W'(cur_len);
            left        <= left - CNT_W'(cur_len);
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (abort) abort_pend <= 1'b1;
          if (axi_RVALID) begin
            if (beat_err && !rrespErr) begin
              rrespErr <= 1'b1;
              rresp    <= axi_RRESP;
            end
            if (axi_RLAST) begin
              if (abort_pend || abort)                     state <= ST_FLUSH;
              else if (rrespErr || beat_err || left == '0) state <= ST_FINISH;
              else                                         state <= ST_WAIT;
            end
          end
        end
        ST_FINISH: begin
          if (abort) begin
            state <= ST_FLUSH;
          end else if (!fifo_valid) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          abort_pend <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  waveform_readback_fifo #(
    .WIDTH(AXI_DATA_WIDTH + 1),
    .DEPTH(FIFO_CAPACITY)
  ) u_fifo (
    .clk   (clk),
    .resetN(resetN),
    .wr    (push),
    .wdata ({beat_last, axi_RDATA}),
    .rd    (m_ready),
    .flush (flush),
    .rdata (fifo_out),
    .valid (fifo_valid),
    .free  (free)
  );

endmodule

// File: tb/tb_waveform_readback.sv
// Bench for waveform_readback: randomized AXI slave backed by a computed buffer
// image, and an expected stream/burst list derived from window arithmetic.
module tb_waveform_readback;
  import waveform_readback_pkg::*;

  localparam int CAP  = 1 << 23;
  localparam int CAPW = 23;
  localparam int BL   = 8;
  localparam int FC   = 32;
  localparam logic [31:0] HI_MASK = ~((32'd1 << (CAPW + 4)) - 32'd1);

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [31:0] base = '0;
  logic [CAPW-1:0] startWord = '0;
  logic [CAPW:0] wordCount = '0;
  logic busy, done, rrespErr;
  logic [1:0] rresp;
  logic [31:0] axi_ARADDR;
  logic [7:0] axi_ARLEN;
  logic [2:0] axi_ARSIZE;
  logic [1:0] axi_ARBURST;
  logic axi_ARVALID, axi_ARREADY, axi_RLAST, axi_RVALID, axi_RREADY;
  logic [127:0] axi_RDATA;
  logic [1:0] axi_RRESP;
  logic [127:0] m_data;
  logic m_valid, m_last, m_ready;

  int tests = 0, fails = 0;
  int done_cnt = 0, extra = 0, beats_tot = 0, popped_tot = 0, burst_no = 0;
  int err_burst = -1, err_beat = -1;
  bit hold = 0, fast = 0, ar_block = 0, check_occ = 0;
  logic [39:0]  ar_exp_q[$], ar_obs_q[$];
  logic [128:0] exp_q[$];

  always #5 clk = ~clk;

  waveform_readback dut (
    .clk(clk), .resetN(resetN), .start(start), .abort(abort), .base(base),
    .startWord(startWord), .wordCount(wordCount), .busy(busy), .done(done),
    .rrespErr(rrespErr), .rresp(rresp), .axi_ARADDR(axi_ARADDR), .axi_ARLEN(axi_ARLEN),
    .axi_ARSIZE(axi_ARSIZE), .axi_ARBURST(axi_ARBURST), .axi_ARVALID(axi_ARVALID),
    .axi_ARREADY(axi_ARREADY), .axi_RDATA(axi_RDATA), .axi_RRESP(axi_RRESP),
    .axi_RLAST(axi_RLAST), .axi_RVALID(axi_RVALID), .axi_RREADY(axi_RREADY),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  function automatic logic [127:0] mem_word(input int unsigned w);
    return {w * 32'h9E3779B1, ~w, w ^ 32'h5A5A_0000, w};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI slave: handshakes are sampled at negedge, new outputs driven just after posedge.
  initial begin : slave
    int pend, word, beat;
    logic ar_hs, r_hs;
    axi_ARREADY = 0; axi_RVALID = 0; axi_RLAST = 0; axi_RRESP = 0; axi_RDATA = '0;
    pend = 0; word = 0; beat = 0;
    forever begin
      @(negedge clk);
      ar_hs = axi_ARVALID && axi_ARREADY;
      r_hs  = axi_RVALID && axi_RREADY;
      if (resetN && ar_hs) begin
        ar_obs_q.push_back({axi_ARADDR, axi_ARLEN});
        if (check_occ) chk("fifo_credit", 160'(beats_tot - popped_tot <= FC - BL), 160'(1));
        word = int'((axi_ARADDR >> 4) & 32'(CAP - 1));
        pend = int'(axi_ARLEN) + 1;
        beat = 0;
        chk("burst_in_buffer", 160'(word + pend <= CAP), 160'(1));
      end
      if (resetN && r_hs) begin
        beats_tot++; pend--; word++; beat++;
        if (pend == 0) burst_no++;
      end
      @(posedge clk); #1;
      if (!resetN) begin
        pend = 0; axi_ARREADY = 0; axi_RVALID = 0; axi_RLAST = 0; axi_RRESP = 0;
        continue;
      end
      if (!(axi_RVALID && !r_hs)) begin
        if (pend > 0 && (fast || $urandom_range(0, 3) != 0)) begin
          axi_RVALID = 1;
          axi_RDATA  = mem_word(word);
          axi_RLAST  = (pend == 1);
          axi_RRESP  = (burst_no == err_burst && beat == err_beat) ? RESP_SLVERR : RESP_OKAY;
        end else begin
          axi_RVALID = 0; axi_RLAST = 0; axi_RRESP = 0;
        end
      end
      axi_ARREADY = (pend == 0) && axi_ARVALID && !ar_block && (fast || $urandom_range(0, 1) == 1);
    end
  end

  initial begin : consumer
    logic [128:0] e;
    m_ready = 0;
    forever begin
      @(negedge clk);
      if (resetN && m_valid && m_ready) begin
        popped_tot++;
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          chk("m_data", 160'(m_data), 160'(e[127:0]));
          chk("m_last", 160'(m_last), 160'(e[128]));
        end
      end
      if (resetN && done) done_cnt++;
      @(posedge clk); #1;
      m_ready = !hold && ($urandom_range(0, 3) != 0);
    end
  end

  task automatic pulse_start(input logic [31:0] b, input int sw, input int wc, input logic ab);
    @(posedge clk); #1;
    base = b; startWord = CAPW'(sw); wordCount = (CAPW+1)'(wc); start = 1; abort = ab;
    @(posedge clk); #1;
    start = 0; abort = 0;
  endtask

  task automatic wait_done(input string tag);
    bit got = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk(tag, 160'(got), 160'(1));
    if (!got) begin
      @(posedge clk); #1 resetN = 0;
      @(posedge clk); #1 resetN = 1;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_run();
    ar_exp_q.delete(); ar_obs_q.delete(); exp_q.delete();
    done_cnt = 0; extra = 0; beats_tot = 0; popped_tot = 0; burst_no = 0;
  endtask

  // Expected bursts: chop the window at BURST_LEN boundaries; an error ends the read after its burst.
  task automatic run_read(input logic [31:0] b, input int sw, input int wc,
                          input int eb, input int ebeat, input bit stall);
    int pos = sw, rem = wc, bidx = 0, n;
    bit stop = 0;
    clear_run();
    err_burst = eb; err_beat = ebeat; check_occ = 1;
    while (rem > 0 && !stop) begin
      n = BL - pos % BL;
      if (n > rem) n = rem;
      ar_exp_q.push_back({(b & HI_MASK) | (32'(pos) << 4), 8'(n - 1)});
      for (int k = 0; k < n; k++)
        exp_q.push_back({(eb < 0) && (rem - k == 1), mem_word((pos + k) % CAP)});
      if (bidx == eb) stop = 1;
      pos = (pos + n) % CAP; rem -= n; bidx++;
    end
    if (stall) begin hold = 1; fast = 1; end
    pulse_start(b, sw, wc, 0);
    if (stall) begin
      repeat (100) @(negedge clk);
      chk("stall_ar_count", 160'(ar_obs_q.size()), 160'(FC / BL));
      hold = 0; fast = 0;
    end
    wait_done("done_timeout");
    chk("words_left", 160'(exp_q.size()), 160'(0));
    chk("extra_words", 160'(extra), 160'(0));
    chk("done_pulses", 160'(done_cnt), 160'(1));
    chk("ar_count", 160'(ar_obs_q.size()), 160'(ar_exp_q.size()));
    for (int i = 0; i < ar_obs_q.size() && i < ar_exp_q.size(); i++)
      chk("ar_addr_len", 160'(ar_obs_q[i]), 160'(ar_exp_q[i]));
    chk("rrespErr", 160'(rrespErr), 160'(eb >= 0));
    chk("rresp", 160'(rresp), 160'((eb >= 0) ? RESP_SLVERR : RESP_OKAY));
    chk("busy_end", 160'(busy), 160'(0));
    check_occ = 0; err_burst = -1; err_beat = -1;
  endtask

  task automatic start_with_ar_blocked();
    clear_run();
    ar_block = 1;
    pulse_start(32'h4000_0000, 0, 32, 0);
    for (int c = 0; c < 50 && !axi_ARVALID; c++) @(negedge clk);
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abort_ar_held", 160'(axi_ARVALID), 160'(1));
    ar_block = 0;
  endtask

  initial begin : main
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 160'({busy, done, axi_ARVALID, m_valid, m_last, rrespErr, rresp}), 160'(0));
    @(posedge clk); #1 resetN = 1;
    @(negedge clk);
    chk("arsize", 160'(axi_ARSIZE), 160'(4));
    chk("arburst", 160'(axi_ARBURST), 160'(BURST_INCR));

    run_read(32'h4000_0000, 0, 20, -1, -1, 0);
    run_read(32'h4000_0000, CAP - 3, 6, -1, -1, 0);
    run_read(32'h4000_0000, 5, 10, -1, -1, 0);
    run_read(32'h4000_0000, 0, 64, -1, -1, 1);
    run_read(32'h8000_0000, 0, 32, 1, 2, 0);
    run_read(32'h4000_0000, 17, 0, -1, -1, 0);
    for (int r = 0; r < 8; r++) begin
      int sw, wc;
      sw = ($urandom_range(0, 1) == 1) ? CAP - int'($urandom_range(1, 20)) : int'($urandom % CAP);
      wc = int'($urandom_range(0, 45));
      run_read($urandom, sw, wc, -1, -1, 0);
    end

    // start together with abort must not begin a readout
    clear_run();
    pulse_start(32'h4000_0000, 0, 16, 1);
    repeat (10) @(negedge clk);
    chk("start_abort_busy", 160'(busy), 160'(0));
    chk("start_abort_arvalid", 160'(axi_ARVALID), 160'(0));
    chk("start_abort_done", 160'(done_cnt), 160'(0));

    // abort while the address is pending: address completes, beats dropped
    start_with_ar_blocked();
    wait_done("abort_done_timeout");
    chk("abort_ar_count", 160'(ar_obs_q.size()), 160'(1));
    chk("abort_done_pulses", 160'(done_cnt), 160'(1));
    chk("abort_words", 160'(extra), 160'(0));
    chk("abort_busy", 160'(busy), 160'(0));

    // abort in ADDR, then reset in the middle of the data burst
    start_with_ar_blocked();
    for (int c = 0; c < 200 && beats_tot == 0; c++) @(negedge clk);
    @(posedge clk); #1 resetN = 0;
    @(negedge clk);
    chk("midburst_reset_outputs",
        160'({busy, done, axi_ARVALID, m_valid, m_last, rrespErr, rresp}), 160'(0));
    repeat (2) @(posedge clk);
    #1 resetN = 1;
    chk("midburst_reset_words", 160'(extra), 160'(0));
    run_read(32'h4000_0000, 3, 25, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/waveform_readback.md
Name: waveform_readback

Overview:
AXI4 read master that fetches a previously recorded waveform from the circular acquisition buffer written by the waveform recorder, and streams it out in order as a valid/ready word stream. Sits in the clk domain between the memory interconnect and the readout path (DMA-to-host or packetiser). Software supplies the buffer base, a start word offset (e.g. the recorder's final write address minus the sample count, modulo capacity) and a word count. The block handles buffer wrap-around, burst sizing and back-pressure.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 128, AXI and output word width; 128 or 256
ACQ_CAPACITY, 1<<23, buffer size in words; power of two, multiple of BURST_LEN
BURST_LEN, 8, maximum beats per burst; power of two, 1..16; BURST_LEN*AXI_DATA_WIDTH/8 ≤ 4096
FIFO_CAPACITY, 32, output FIFO depth in words; power of two, ≥ 2*BURST_LEN

Ports:
clk  in  1  single clock; all logic on rising edge
resetN  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches base/startWord/wordCount; ignored while busy
abort  in  1  one-cycle pulse; terminate the current readout
base  in  AXI_ADDR_WIDTH  buffer base; bits below log2(ACQ_CAPACITY)+log2(AXI_DATA_WIDTH/8) are ignored
startWord  in  log2(ACQ_CAPACITY)  first word offset
wordCount  in  log2(ACQ_CAPACITY+1)  words to read; 0 is legal
busy  out  1  readout in progress
done  out  1  one-cycle pulse at completion, error or abort
rrespErr  out  1  sticky; an error RRESP occurred; cleared by start
rresp  out  2  first non-OKAY RRESP captured
axi_ARADDR  out  AXI_ADDR_WIDTH  base upper bits, readAddr, zero alignment bits
axi_ARLEN  out  8  beats-1
axi_ARSIZE  out  3  log2(AXI_DATA_WIDTH/8), constant
axi_ARBURST  out  2  INCR (01), constant
axi_ARVALID  out  1
axi_ARREADY  in  1
axi_RDATA  in  AXI_DATA_WIDTH
axi_RRESP  in  2
axi_RLAST  in  1
axi_RVALID  in  1
axi_RREADY  out  1  constant 1 outside IDLE; FIFO space is guaranteed by the credit rule
m_data  out  AXI_DATA_WIDTH  stream word
m_valid  out  1
m_last  out  1  marks the final requested word
m_ready  in  1

Behaviour:
- Reset: state IDLE. ARVALID, busy, done, rrespErr, m_valid and m_last are 0. rresp=0. FIFO empty. The reset may arrive at any time, including mid-burst; the interconnect is reset together with this block.
- States:
  - IDLE: on start, latch readAddr=startWord and left=wordCount; clear rrespErr/rresp; busy=1. If wordCount==0, pulse done the next cycle and stay IDLE. Otherwise go to WAIT.
  - WAIT: when FIFO free space ≥ BURST_LEN, compute len=min(BURST_LEN − (readAddr mod BURST_LEN), left), drive ARLEN=len−1, assert ARVALID, go to ADDR. Alignment keeps every burst inside a 4 KB page and inside the buffer.
  - ADDR: hold ARADDR/ARLEN stable until ARREADY. On handshake, drop ARVALID; readAddr += len, wrapping to 0 at ACQ_CAPACITY; left −= len; go to DATA.
  - DATA: each R beat is pushed into the FIFO. The first RRESP≠0 sets rrespErr and latches rresp. On RLAST: if abort is pending, go to FLUSH; else if rrespErr is set or left==0, go to FINISH; else go to WAIT.
  - FINISH: wait until the FIFO is empty (all words consumed); pulse done; go to IDLE.
  - FLUSH: clear the FIFO in one cycle; pulse done; go to IDLE.
- One burst outstanding at a time. RREADY is never deasserted mid-burst.
- Abort:
  - In WAIT: go straight to FLUSH.
  - In ADDR: the address must still complete (AXI forbids withdrawing ARVALID); complete it, then DATA, then FLUSH. Data beats after an abort are discarded, not pushed.
- m_last=1 on the final word when no abort and no error occurred. After an error, the words already read are still streamed, but m_last is not asserted; the consumer uses done/rrespErr.
- Stream: m_data/m_valid come from a first-word-fall-through FIFO and hold until m_ready. Latency from the RVALID beat to m_valid is 1 cycle.
- start with abort in the same cycle: abort wins; no readout begins.

Decomposition:
- Shared package: AXI burst/size/resp encodings (INCR, OKAY/SLVERR/DECERR) and the state encoding. The state encoding is shared with the recorder so status readback decodes uniformly.
- One sub-module: waveform_readback_fifo, a synchronous FWFT FIFO with a free-count output. Everything else lives in the top level.

Test Plan:
- base=0x4000_0000, startWord=0, wordCount=20, BURST_LEN=8 → AR lengths 8,8,4 at addresses 0x4000_0000, +0x80, +0x100; 20 words in order; m_last on word 20; one done pulse.
- startWord=ACQ_CAPACITY−3, wordCount=6 → bursts of 3 beats at the buffer top and 3 beats at offset 0; no burst crosses the wrap.
- startWord=5, wordCount=10 → first burst 3 beats (to the 8-word boundary), then 7 beats.
- m_ready held low for 100 cycles with wordCount=64, FIFO_CAPACITY=32 → no AR issued while FIFO free space < 8; no data lost; order preserved.
- SLVERR (10) on beat 3 of the second burst → that burst completes, no further AR, rresp=2'b10, rrespErr=1, done pulses, m_last never asserted.
- abort during ADDR, then resetN low mid-DATA → AR completes and beats are discarded; after reset all outputs are 0 and the block is IDLE; a new start runs normally.
